// File: rtl/menu_navegacao.sv
`default_nettype none
// ============================================================================
// Module   : menu_navegacao
// Brief    : Menu responder for the FPGAudio control unit. Synchronises the
//            player buttons, moves a wrapped option cursor inside the menu
//            chosen by menu_sel, emits a one-cycle confirm pulse and latches
//            the mode / error / BPM / key / song selections.
// Revision : 1.0 - initial release
// ============================================================================
module menu_navegacao #(
  parameter int MODO      = 4,
  parameter int ERRO      = 3,
  parameter int N_BPM     = 4,
  parameter int N_TOM     = 12,
  parameter int N_MUSICAS = 16
) (
  input  logic            clock_i,
  input  logic            reset_ni,
  input  logic            inicia_menu_i,
  input  logic [2:0]      menu_sel_i,
  input  logic            registra_modo_i,
  input  logic            registra_bpm_i,
  input  logic            registra_tom_i,
  input  logic            registra_musicas_i,
  input  logic            botao_cima_i,
  input  logic            botao_baixo_i,
  input  logic            botao_enter_i,
  output logic            press_enter_o,
  output logic [3:0]      cursor_o,
  output logic [MODO-1:0] modos_o,
  output logic [ERRO-1:0] erros_o,
  output logic [1:0]      bpm_o,
  output logic [3:0]      tom_o,
  output logic [3:0]      musica_o,
  output logic [1:0]      db_estado_o
);

  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    NAVEGA       = 2'd1,
    CONFIRMA     = 2'd2,
    ESPERA_SOLTA = 2'd3
  } estado_t;

  // Highest valid index of each menu (option count minus one).
  localparam logic [3:0] c_ult_modo    = 4'(MODO - 1);
  localparam logic [3:0] c_ult_erro    = 4'(ERRO - 1);
  localparam logic [3:0] c_ult_bpm     = 4'(N_BPM - 1);
  localparam logic [3:0] c_ult_tom     = 4'(N_TOM - 1);
  localparam logic [3:0] c_ult_musicas = 4'(N_MUSICAS - 1);

  // Button vectors are ordered {enter, baixo, cima}.
  logic [2:0] btn_raw;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] sync3_q;
  logic [2:0] edge_q;
  logic [2:0] sel_q;

  estado_t    estado_q;
  logic [3:0] cursor_q;
  logic       press_q;

  logic [MODO-1:0] modos_q;
  logic [ERRO-1:0] erros_q;
  logic [1:0]      bpm_q;
  logic [3:0]      tom_q;
  logic [3:0]      musica_q;

  logic [3:0] ultimo_d;
  logic [3:0] cur_dec_d;
  logic [3:0] cur_inc_d;
  logic       sel_mudou;

  assign btn_raw   = {botao_enter_i, botao_baixo_i, botao_cima_i};
  assign sel_mudou = (menu_sel_i != sel_q);

  // Two-flop synchroniser, one extra stage for edge detection, registered pulse.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      sync3_q <= 3'b000;
      edge_q  <= 3'b000;
      sel_q   <= 3'b000;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
      sel_q   <= menu_sel_i;
    end
  end

  // Wrap-around neighbours of the cursor inside the active menu.
  always_comb begin
    ultimo_d = c_ult_modo;
    if (menu_sel_i[2]) begin
      ultimo_d = c_ult_erro;
    end else begin
      case (menu_sel_i[1:0])
        2'b00:   ultimo_d = c_ult_modo;
        2'b01:   ultimo_d = c_ult_bpm;
        2'b10:   ultimo_d = c_ult_tom;
        default: ultimo_d = c_ult_musicas;
      endcase
    end
    cur_dec_d = (cursor_q == 4'd0)     ? ultimo_d : cursor_q - 4'd1;
    cur_inc_d = (cursor_q == ultimo_d) ? 4'd0     : cursor_q + 4'd1;
  end

  // Navigation FSM: cursor movement, confirm pulse and release wait.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      estado_q <= OCIOSO;
      cursor_q <= 4'd0;
      press_q  <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (inicia_menu_i) begin
        estado_q <= NAVEGA;
        cursor_q <= 4'd0;
      end else begin
        case (estado_q)
          OCIOSO: begin
            estado_q <= OCIOSO;
          end
          NAVEGA: begin
            if (edge_q[2]) begin
              estado_q <= CONFIRMA;
              press_q  <= 1'b1;
            end else if (edge_q[0] && !edge_q[1]) begin
              cursor_q <= cur_dec_d;
            end else if (edge_q[1] && !edge_q[0]) begin
              cursor_q <= cur_inc_d;
            end
          end
          CONFIRMA: begin
            estado_q <= ESPERA_SOLTA;
            cursor_q <= 4'd0;
          end
          default: begin
            if (!sync2_q[2]) begin
              estado_q <= NAVEGA;
            end
          end
        endcase
        // A menu switch zeroes the cursor so it never exceeds a smaller menu.
        if (estado_q != OCIOSO && sel_mudou) begin
          cursor_q <= 4'd0;
        end
      end
    end
  end

  // Selection latches; frozen while confirming so values are stable on press.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      modos_q  <= '0;
      erros_q  <= '0;
      bpm_q    <= 2'd0;
      tom_q    <= 4'd0;
      musica_q <= 4'd0;
    end else if (estado_q == OCIOSO || estado_q == NAVEGA) begin
      if (registra_modo_i) begin
        modos_q <= MODO'(1) << cursor_q;
      end
      if (registra_bpm_i) begin
        bpm_q <= cursor_q[1:0];
      end
      if (registra_tom_i) begin
        tom_q <= cursor_q;
      end
      if (registra_musicas_i) begin
        musica_q <= cursor_q;
      end
      if (estado_q == NAVEGA && menu_sel_i[2]) begin
        erros_q <= ERRO'(1) << cursor_q;
      end
    end
  end

  assign press_enter_o = press_q;
  assign cursor_o      = cursor_q;
  assign modos_o       = modos_q;
  assign erros_o       = erros_q;
  assign bpm_o         = bpm_q;
  assign tom_o         = tom_q;
  assign musica_o      = musica_q;
  assign db_estado_o   = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_menu_navegacao.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_menu_navegacao
// Brief    : Self-checking bench for menu_navegacao; directed scenarios
//            followed by random button traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_menu_navegacao;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       inicia_menu;
  logic [2:0] menu_sel;
  logic       registra_modo, registra_bpm, registra_tom, registra_musicas;
  logic       botao_cima, botao_baixo, botao_enter;
  logic       press_enter;
  logic [3:0] cursor;
  logic [3:0] modos;
  logic [2:0] erros;
  logic [1:0] bpm;
  logic [3:0] tom;
  logic [3:0] musica;
  logic [1:0] db_estado;

  always #5 clock = ~clock;

  menu_navegacao dut (
    .clock_i            (clock),
    .reset_ni           (reset_n),
    .inicia_menu_i      (inicia_menu),
    .menu_sel_i         (menu_sel),
    .registra_modo_i    (registra_modo),
    .registra_bpm_i     (registra_bpm),
    .registra_tom_i     (registra_tom),
    .registra_musicas_i (registra_musicas),
    .botao_cima_i       (botao_cima),
    .botao_baixo_i      (botao_baixo),
    .botao_enter_i      (botao_enter),
    .press_enter_o      (press_enter),
    .cursor_o           (cursor),
    .modos_o            (modos),
    .erros_o            (erros),
    .bpm_o              (bpm),
    .tom_o              (tom),
    .musica_o           (musica),
    .db_estado_o        (db_estado)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: state number, cursor, and latched selections.
  int m_state, m_cur, m_press, m_modos, m_erros, m_bpm, m_tom, m_mus, m_selprev;
  int hc[$];
  int hb[$];
  int he[$];

  int npress;
  int snap_cur, snap_modos, snap_erros;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int hist(input int q[$], input int k);
    if (k < q.size()) return q[q.size() - 1 - k];
    return 0;
  endfunction

  function automatic int lim_of(input logic [2:0] s);
    if (s[2]) return 3;
    case (s[1:0])
      2'b00:   return 4;
      2'b01:   return 4;
      2'b10:   return 12;
      default: return 16;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_cur = 0; m_press = 0; m_modos = 0; m_erros = 0;
    m_bpm = 0; m_tom = 0; m_mus = 0; m_selprev = 0;
    hc.delete(); hb.delete(); he.delete();
  endtask

  task automatic check_all();
    chk("db_estado", db_estado, m_state);
    chk("cursor", cursor, m_cur);
    chk("press_enter", press_enter, m_press);
    chk("modos", modos, m_modos);
    chk("erros", erros, m_erros);
    chk("bpm", bpm, m_bpm);
    chk("tom", tom, m_tom);
    chk("musica", musica, m_mus);
  endtask

  // One clock: predict from the inputs present before the edge, then compare.
  task automatic tick();
    int lim, ec, eb, ee, es, ns, nc;
    hc.push_back(int'(botao_cima));
    hb.push_back(int'(botao_baixo));
    he.push_back(int'(botao_enter));
    if (hc.size() > 8) begin
      void'(hc.pop_front()); void'(hb.pop_front()); void'(he.pop_front());
    end
    lim = lim_of(menu_sel);
    // A pin rise is acted upon three edges after it is first sampled.
    ec = (hist(hc, 3) == 1 && hist(hc, 4) == 0) ? 1 : 0;
    eb = (hist(hb, 3) == 1 && hist(hb, 4) == 0) ? 1 : 0;
    ee = (hist(he, 3) == 1 && hist(he, 4) == 0) ? 1 : 0;
    es = hist(he, 2);
    ns = m_state; nc = m_cur;
    if (inicia_menu) begin
      ns = 1; nc = 0;
    end else begin
      if (m_state == 1) begin
        if (ee == 1) ns = 2;
        else if (ec == 1 && eb == 0) nc = (m_cur + lim - 1) % lim;
        else if (eb == 1 && ec == 0) nc = (m_cur + 1) % lim;
      end else if (m_state == 2) begin
        ns = 3; nc = 0;
      end else if (m_state == 3) begin
        if (es == 0) ns = 1;
      end
      if (m_state != 0 && int'(menu_sel) != m_selprev) nc = 0;
    end
    if (m_state <= 1) begin
      if (registra_modo)    m_modos = (1 << m_cur) & 15;
      if (registra_bpm)     m_bpm   = m_cur & 3;
      if (registra_tom)     m_tom   = m_cur;
      if (registra_musicas) m_mus   = m_cur;
      if (m_state == 1 && menu_sel[2]) m_erros = (1 << m_cur) & 7;
    end
    m_press   = (m_state == 1 && ns == 2) ? 1 : 0;
    m_selprev = int'(menu_sel);
    m_state   = ns;
    m_cur     = nc;
    @(posedge clock);
    @(negedge clock);
    check_all();
    if (press_enter === 1'b1) begin
      npress++;
      snap_cur   = int'(cursor);
      snap_modos = int'(modos);
      snap_erros = int'(erros);
    end
  endtask

  // mask bit0=cima, bit1=baixo, bit2=enter
  task automatic press(input int mask, input int hold);
    if (mask & 1) botao_cima  = 1'b1;
    if (mask & 2) botao_baixo = 1'b1;
    if (mask & 4) botao_enter = 1'b1;
    repeat (hold) tick();
    if (mask & 1) botao_cima  = 1'b0;
    if (mask & 2) botao_baixo = 1'b0;
    if (mask & 4) botao_enter = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    reset_n = 1'b0; inicia_menu = 1'b0; menu_sel = 3'b000;
    registra_modo = 1'b0; registra_bpm = 1'b0; registra_tom = 1'b0; registra_musicas = 1'b0;
    botao_cima = 1'b0; botao_baixo = 1'b0; botao_enter = 1'b0;
    npress = 0; snap_cur = 0; snap_modos = 0; snap_erros = 0;
    model_reset();
    @(negedge clock);
    #2 reset_n = 1'b1;
    tick();
    chk("reset_state", db_estado, 0);

    // Async reset in the middle of navigation with cursor at 3.
    inicia_menu = 1'b1; tick(); inicia_menu = 1'b0;
    registra_modo = 1'b1;
    press(2, 2); press(2, 2); press(2, 2);
    registra_modo = 1'b0;
    chk("pre_reset_cursor", cursor, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_estado", db_estado, 0);
    chk("async_rst_cursor", cursor, 0);
    chk("async_rst_modos", modos, 0);
    chk("async_rst_press", press_enter, 0);
    model_reset();
    @(negedge clock);
    #2 reset_n = 1'b1;
    tick();

    // Mode menu: two steps down, latch, confirm.
    menu_sel = 3'b000;
    inicia_menu = 1'b1; tick(); inicia_menu = 1'b0;
    press(2, 2); press(2, 2);
    chk("modo_cursor", cursor, 2);
    registra_modo = 1'b1;
    npress = 0;
    press(4, 2);
    registra_modo = 1'b0;
    chk("modo_npress", npress, 1);
    chk("modo_snap_cursor", snap_cur, 2);
    chk("modo_snap_modos", snap_modos, 4);

    // Key menu: wrap downward from 0 and back.
    menu_sel = 3'b010;
    tick();
    registra_tom = 1'b1;
    press(1, 2);
    chk("tom_wrap_cursor", cursor, 11);
    chk("tom_wrap_tom", tom, 11);
    registra_tom = 1'b0;
    press(2, 2);
    chk("tom_wrap_back", cursor, 0);
    chk("tom_held", tom, 11);

    // Long enter hold with cima pressed in the middle.
    press(2, 2); press(2, 2); press(2, 2);
    chk("hold_pre_cursor", cursor, 3);
    npress = 0;
    botao_enter = 1'b1;
    repeat (10) tick();
    chk("hold_estado", db_estado, 3);
    botao_cima = 1'b1; repeat (2) tick(); botao_cima = 1'b0;
    repeat (8) tick();
    chk("hold_cima_ignored", cursor, 0);
    botao_enter = 1'b0;
    repeat (6) tick();
    chk("hold_npress", npress, 1);
    chk("hold_release_estado", db_estado, 1);
    chk("hold_release_cursor", cursor, 0);

    // Simultaneous buttons.
    press(2, 2);
    press(3, 2);
    chk("cima_baixo_same", cursor, 1);
    npress = 0;
    press(6, 2);
    chk("enter_baixo_npress", npress, 1);
    chk("enter_baixo_cursor", snap_cur, 1);

    // Error menu: select second entry, confirm, then leave the menu.
    menu_sel = 3'b100;
    tick();
    press(2, 2);
    chk("erro_sel", erros, 2);
    npress = 0;
    press(4, 2);
    chk("erro_npress", npress, 1);
    chk("erro_snap", snap_erros, 2);
    press(2, 2);
    chk("erro_cursor1", cursor, 1);
    menu_sel = 3'b001;
    tick();
    chk("sel_change_zero", cursor, 0);

    // Song menu then shrink to BPM menu with cursor at 14.
    menu_sel = 3'b011; tick();
    press(1, 2); press(1, 2);
    chk("mus_cursor14", cursor, 14);
    menu_sel = 3'b001; tick();
    chk("shrink_zero", cursor, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) botao_cima  = ~botao_cima;
      if ($urandom_range(0, 5) == 0) botao_baixo = ~botao_baixo;
      if ($urandom_range(0, 7) == 0) botao_enter = ~botao_enter;
      inicia_menu = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) menu_sel = 3'($urandom);
      registra_modo    = ($urandom_range(0, 7) == 0);
      registra_bpm     = ($urandom_range(0, 7) == 0);
      registra_tom     = ($urandom_range(0, 7) == 0);
      registra_musicas = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
